arashi_cache_sched: RTL and testbench

Read scheduler for the per-thread cache array. It picks one thread with data available using round-robin arbitration among enabled threads. It drives the cache's single read port (`toread`/`rcache`) and captures the returned word one cycle later. It presents the word with its thread ID to a ready/valid consumer through a 2-entry output buffer, sustaining one word per cycle under full downstream throughput.

---
 rtl/arashi_cache_sched.sv | 141 ++++++++++++++
 tb/tb_arashi_cache_sched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arashi_cache_sched.sv
// arashi_cache_sched: round-robin read scheduler for the per-thread cache array.
// Picks one eligible thread per cycle, strobes the cache read port, captures the
// returned word a cycle later and hands {tid, data} to a ready/valid consumer
// through a 2-entry buffer.
module arashi_cache_sched #(
    parameter int DATA_WIDTH       = 32,
    parameter int THREAD_NUM_WIDTH = 2,
    localparam int THREAD_NUM      = 1 << THREAD_NUM_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [THREAD_NUM-1:0]       avail,
    input  logic [THREAD_NUM-1:0]       sched_en,
    input  logic [DATA_WIDTH-1:0]       cache_data,
    output logic [THREAD_NUM_WIDTH-1:0] toread,
    output logic                        rcache,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [THREAD_NUM_WIDTH-1:0] out_tid
);

    logic [THREAD_NUM_WIDTH-1:0] last;
    logic [THREAD_NUM_WIDTH-1:0] inflight_tid;
    logic                        inflight;
    logic [THREAD_NUM_WIDTH-1:0] grant;
    logic [THREAD_NUM_WIDTH-1:0] scan_idx;
    logic                        found;
    logic [THREAD_NUM-1:0]       eligible;
    logic [2:0]                  occupancy;
    logic                        space_ok;
    logic                        issue;
    logic                        pop;
    logic                        push;
    logic [1:0]                  count;
    logic [THREAD_NUM_WIDTH-1:0] head_tid;
    logic [DATA_WIDTH-1:0]       head_data;
    logic [THREAD_NUM_WIDTH-1:0] tail_tid;
    logic [DATA_WIDTH-1:0]       tail_data;

    // Output handshake and capture: the word read last cycle always lands this cycle.
    assign out_valid = (count != 2'd0);
    assign out_data  = head_data;
    assign out_tid   = head_tid;
    assign pop       = out_valid & out_ready;
    assign push      = inflight;

    // A thread is eligible if it has data, is enabled, and was not read last
    // cycle (its avail bit may still be stale after that pop).
    always_comb begin
        eligible = '0;
        for (int i = 0; i < THREAD_NUM; i++) begin
            eligible[i] = avail[i] & sched_en[i]
                        & ~(inflight && (inflight_tid == THREAD_NUM_WIDTH'(i)));
        end
    end

    // Round-robin scan starting just after the last granted thread.
    always_comb begin
        found    = 1'b0;
        grant    = last;
        scan_idx = last;
        for (int k = 1; k <= THREAD_NUM; k++) begin
            scan_idx = last + THREAD_NUM_WIDTH'(k);
            if (!found && eligible[scan_idx]) begin
                found = 1'b1;
                grant = scan_idx;
            end
        end
    end

    // Issue only if the buffer can absorb this word counting the one already in flight.
    always_comb begin
        occupancy = {1'b0, count} + {2'b00, inflight};
        space_ok  = occupancy < (3'd2 + {2'b00, pop});
        issue     = space_ok & found & ~rst;
        rcache    = issue;
        toread    = rst ? '0 : (issue ? grant : last);
    end

    // Scheduler state: round-robin pointer and the in-flight read marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last         <= THREAD_NUM_WIDTH'(THREAD_NUM - 1);
            inflight     <= 1'b0;
            inflight_tid <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                last         <= grant;
                inflight_tid <= grant;
            end
        end
    end

    // Two-entry output buffer; the head only changes on a pop or when filling an empty buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= 2'd0;
            head_tid  <= '0;
            head_data <= '0;
            tail_tid  <= '0;
            tail_data <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_tid  <= inflight_tid;
                        head_data <= cache_data;
                    end else begin
                        tail_tid  <= inflight_tid;
                        tail_data <= cache_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_tid  <= tail_tid;
                    head_data <= tail_data;
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_tid  <= inflight_tid;
                        head_data <= cache_data;
                    end else begin
                        head_tid  <= tail_tid;
                        head_data <= tail_data;
                        tail_tid  <= inflight_tid;
                        tail_data <= cache_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // A capture into a full buffer with no pop would lose a word.
    assert property (@(posedge clk) disable iff (rst) !(push && !pop && count == 2'd2));

endmodule

// File: tb/tb_arashi_cache_sched.sv
// tb_arashi_cache_sched: directed-vector bench for arashi_cache_sched.
// Inputs change 1 time unit after each rising edge, outputs are checked 1 unit
// later; a small cache model returns a tagged word the cycle after each rcache.
module tb_arashi_cache_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  avail;
    logic [3:0]  sched_en;
    logic [31:0] cache_data;
    logic [1:0]  toread;
    logic        rcache;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_tid;

    int n_checks = 0;
    int n_fail   = 0;
    int seq      = 0;

    logic [1:0] rr_grants [8] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd1};
    logic [1:0] mask_grants [5] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0};
    logic [3:0] mask_en [5] = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0001};

    arashi_cache_sched #(.DATA_WIDTH(32), .THREAD_NUM_WIDTH(2)) dut (
        .clk(clk),
        .rst(rst),
        .avail(avail),
        .sched_en(sched_en),
        .cache_data(cache_data),
        .toread(toread),
        .rcache(rcache),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_tid(out_tid)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word the cache model returns for a given thread and read sequence number.
    function automatic logic [31:0] mkword(input logic [1:0] tid, input int s);
        return {6'b110000, tid, 24'(s)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] e, input logic r);
        avail     = a;
        sched_en  = e;
        out_ready = r;
        #1;
    endtask

    // Advance one cycle; the cache answers the read strobed in the cycle just ended.
    task automatic tick();
        logic       r;
        logic [1:0] t;
        r = rcache;
        t = toread;
        @(posedge clk);
        #1;
        if (r) begin
            cache_data = mkword(t, seq);
            seq++;
        end else begin
            cache_data = '0;
        end
    endtask

    initial begin
        rst        = 1'b1;
        avail      = '0;
        sched_en   = 4'hF;
        out_ready  = 1'b1;
        cache_data = '0;
        @(posedge clk);
        #1;

        // Held in reset with data available: everything stays quiet.
        applyStimulus(4'hF, 4'hF, 1'b1);
        checkOutput("rst_rcache", rcache, 0);
        checkOutput("rst_toread", toread, 0);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_data", out_data, 0);
        checkOutput("rst_tid", out_tid, 0);
        applyStimulus(4'h0, 4'hF, 1'b1);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checkOutput("idle_rcache", rcache, 0);
            checkOutput("idle_valid", out_valid, 0);
            tick();
            applyStimulus(4'h0, 4'hF, 1'b1);
        end

        // Round robin over threads 0,1,3 at full throughput.
        seq = 0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b1011, 4'hF, 1'b1);
            checkOutput("rr_rcache", rcache, 1);
            checkOutput("rr_toread", toread, rr_grants[k]);
            if (k >= 2) begin
                checkOutput("rr_valid", out_valid, 1);
                checkOutput("rr_tid", out_tid, rr_grants[k-2]);
                checkOutput("rr_data", out_data, mkword(rr_grants[k-2], k - 2));
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'h0, 4'hF, 1'b1);
            tick();
        end
        applyStimulus(4'h0, 4'hF, 1'b1);
        checkOutput("rr_drained", out_valid, 0);

        // Single word on thread 2; avail lags one cycle but must not cause a second read.
        seq = 100;
        applyStimulus(4'b0100, 4'hF, 1'b1);
        checkOutput("single_rcache", rcache, 1);
        checkOutput("single_toread", toread, 2);
        tick();
        applyStimulus(4'b0100, 4'hF, 1'b1);
        checkOutput("single_lag_rcache", rcache, 0);
        tick();
        applyStimulus(4'h0, 4'hF, 1'b1);
        checkOutput("single_valid", out_valid, 1);
        checkOutput("single_tid", out_tid, 2);
        checkOutput("single_data", out_data, mkword(2'd2, 100));
        checkOutput("single_rcache2", rcache, 0);
        tick();
        applyStimulus(4'h0, 4'hF, 1'b1);
        checkOutput("single_done", out_valid, 0);

        // Backpressure: two reads fill the buffer, then issue stalls with a stable head.
        seq = 200;
        applyStimulus(4'hF, 4'hF, 1'b0);
        checkOutput("bp_rcache0", rcache, 1);
        checkOutput("bp_toread0", toread, 3);
        tick();
        applyStimulus(4'hF, 4'hF, 1'b0);
        checkOutput("bp_rcache1", rcache, 1);
        checkOutput("bp_toread1", toread, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'hF, 4'hF, 1'b0);
            checkOutput("bp_stall_rcache", rcache, 0);
            checkOutput("bp_stall_valid", out_valid, 1);
            checkOutput("bp_stall_tid", out_tid, 3);
            checkOutput("bp_stall_data", out_data, mkword(2'd3, 200));
            tick();
        end
        applyStimulus(4'hF, 4'hF, 1'b1);
        checkOutput("bp_resume_rcache", rcache, 1);
        checkOutput("bp_resume_toread", toread, 1);
        checkOutput("bp_drain_tid0", out_tid, 3);
        tick();
        applyStimulus(4'hF, 4'hF, 1'b1);
        checkOutput("bp_toread_b6", toread, 2);
        checkOutput("bp_drain_tid1", out_tid, 0);
        checkOutput("bp_drain_data1", out_data, mkword(2'd0, 201));
        tick();
        applyStimulus(4'hF, 4'hF, 1'b1);
        checkOutput("bp_toread_b7", toread, 3);
        checkOutput("bp_drain_tid2", out_tid, 1);
        checkOutput("bp_drain_data2", out_data, mkword(2'd1, 202));
        tick();
        applyStimulus(4'h0, 4'hF, 1'b1);
        checkOutput("bp_idle_rcache", rcache, 0);
        checkOutput("bp_drain_data3", out_data, mkword(2'd2, 203));
        tick();
        applyStimulus(4'h0, 4'hF, 1'b1);
        checkOutput("bp_drain_tid4", out_tid, 3);
        checkOutput("bp_drain_data4", out_data, mkword(2'd3, 204));
        tick();
        applyStimulus(4'h0, 4'hF, 1'b1);
        checkOutput("bp_empty", out_valid, 0);

        // Mask: only threads 0 and 2; thread 2 is disabled while its read is in flight.
        seq = 300;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'hF, mask_en[k], 1'b1);
            checkOutput("mask_rcache", rcache, 1);
            checkOutput("mask_toread", toread, mask_grants[k]);
            if (k >= 2) begin
                checkOutput("mask_tid", out_tid, mask_grants[k-2]);
                checkOutput("mask_data", out_data, mkword(mask_grants[k-2], 300 + k - 2));
            end
            tick();
        end
        applyStimulus(4'hF, 4'b0001, 1'b1);
        checkOutput("mask_excl_rcache", rcache, 0);
        checkOutput("mask_late_valid", out_valid, 1);
        checkOutput("mask_late_tid", out_tid, 2);
        checkOutput("mask_late_data", out_data, mkword(2'd2, 303));
        tick();
        applyStimulus(4'hF, 4'b0001, 1'b1);
        checkOutput("mask_last_rcache", rcache, 1);
        checkOutput("mask_last_toread", toread, 0);
        checkOutput("mask_last_tid", out_tid, 0);

        // Asynchronous reset mid-operation clears outputs immediately.
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_rcache", rcache, 0);
        checkOutput("mid_rst_toread", toread, 0);
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_data", out_data, 0);
        checkOutput("mid_rst_tid", out_tid, 0);
        rst = 1'b0;

        // Pointer restarts at 3: threads 0 and 3 alternate, starting with 0.
        seq = 400;
        applyStimulus(4'b1001, 4'hF, 1'b1);
        checkOutput("wrap_rcache0", rcache, 1);
        checkOutput("wrap_toread0", toread, 0);
        checkOutput("wrap_valid0", out_valid, 0);
        tick();
        applyStimulus(4'b1001, 4'hF, 1'b1);
        checkOutput("wrap_toread1", toread, 3);
        checkOutput("wrap_valid1", out_valid, 0);
        tick();
        applyStimulus(4'b1001, 4'hF, 1'b1);
        checkOutput("wrap_toread2", toread, 0);
        checkOutput("wrap_tid2", out_tid, 0);
        checkOutput("wrap_data2", out_data, mkword(2'd0, 400));
        tick();
        applyStimulus(4'b1001, 4'hF, 1'b1);
        checkOutput("wrap_toread3", toread, 3);
        checkOutput("wrap_tid3", out_tid, 3);
        checkOutput("wrap_data3", out_data, mkword(2'd3, 401));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
